// File: rtl/oled_status_writer.sv
// ---------------------------------------------------------------------------
// oled_status_writer
//   Formats a "label + hex value" status request as one 16-character ASCII row
//   and streams it into the OLEDCtrl character-write port, one char per
//   handshake, optionally followed by a display update.
//
//   Row layout (col 0..15):
//     L0 L1 ':' h[D-1] .. h[0] ' ' ...     (D = VALUE_WIDTH/4 hex digits)
//
// Parameters
//   VALUE_WIDTH       width of req_value, multiple of 4, 4..48
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_*             request handshake (valid/ready) and payload
//   busy, done        busy from accept through the done pulse; done = 1-cycle pulse
//   write_*           OLEDCtrl char-write port (start strobe, char, base address, ready)
//   update_*          OLEDCtrl update port (start strobe, clear tied 0, ready)
//
// Build option
//   OLED_STATUS_AUTO_UPDATE_EN  when defined, every row ends with one
//   update_start handshake; otherwise update_start stays 0 and update_ready
//   is ignored.
// ---------------------------------------------------------------------------
module oled_status_writer #(
    parameter int VALUE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_row,
    input  logic [15:0]            req_label,
    input  logic [VALUE_WIDTH-1:0] req_value,
    output logic                   busy,
    output logic                   done,
    output logic                   write_start,
    output logic [7:0]             write_ascii_data,
    output logic [8:0]             write_base_addr,
    input  logic                   write_ready,
    output logic                   update_start,
    output logic                   update_clear,
    input  logic                   update_ready
);

    localparam int D = VALUE_WIDTH / 4;

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, WR_ACK, WR_DONE, UPD_ISSUE, UPD_ACK, UPD_DONE, FINISH
    } state_t;

    typedef struct packed {
        logic [1:0]             row;
        logic [15:0]            label;
        logic [VALUE_WIDTH-1:0] value;
    } req_t;

    state_t     state, state_n;
    req_t       req_q;
    logic [3:0] col_q;
    logic [7:0] char_c;
    logic [3:0] nib;
    logic       in_hex;
    logic       accept;
    logic       wr_fire;

    assign update_clear = 1'b0;
    assign accept       = (state == IDLE) && req_valid && req_ready;
    assign wr_fire      = (state == WR_ISSUE) && write_ready;

    function automatic logic [7:0] printable(input logic [7:0] b);
        return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h3F;
    endfunction

    // Hex digit for the current column; digit k sits at col 3+k, MSB first.
    always_comb begin
        nib    = '0;
        in_hex = 1'b0;
        for (int k = 0; k < D; k++) begin
            if (col_q == 4'(k + 3)) begin
                in_hex = 1'b1;
                nib    = req_q.value[VALUE_WIDTH-1-4*k -: 4];
            end
        end
    end

    always_comb begin
        char_c = 8'h20;
        case (col_q)
            4'd0:    char_c = printable(req_q.label[15:8]);
            4'd1:    char_c = printable(req_q.label[7:0]);
            4'd2:    char_c = 8'h3A;
            default: begin
                if (in_hex)
                    char_c = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
            end
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (accept) state_n = WR_ISSUE;
            WR_ISSUE:  if (write_ready) state_n = WR_ACK;
            WR_ACK:    if (!write_ready) state_n = WR_DONE;
            WR_DONE: begin
                if (write_ready) begin
                    if (col_q != 4'd15)
                        state_n = WR_ISSUE;
                    else
`ifdef OLED_STATUS_AUTO_UPDATE_EN
                        state_n = UPD_ISSUE;
`else
                        state_n = FINISH;
`endif
                end
            end
`ifdef OLED_STATUS_AUTO_UPDATE_EN
            UPD_ISSUE: if (update_ready) state_n = UPD_ACK;
            UPD_ACK:   if (!update_ready) state_n = UPD_DONE;
            UPD_DONE:  if (update_ready) state_n = FINISH;
`endif
            FINISH:    state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

`ifndef OLED_STATUS_AUTO_UPDATE_EN
    logic unused_update_ready;
    assign unused_update_ready = update_ready;
`endif

    // All outputs registered. done is raised from FINISH so it lands in the
    // first IDLE cycle; busy is stretched over that same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            req_q            <= '0;
            col_q            <= '0;
            req_ready        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            write_start      <= 1'b0;
            write_ascii_data <= '0;
            write_base_addr  <= '0;
            update_start     <= 1'b0;
        end else begin
            state       <= state_n;
            req_ready   <= (state_n == IDLE);
            busy        <= (state_n != IDLE) || (state == FINISH);
            done        <= (state == FINISH);
            write_start <= wr_fire;
`ifdef OLED_STATUS_AUTO_UPDATE_EN
            update_start <= (state == UPD_ISSUE) && update_ready;
`else
            update_start <= 1'b0;
`endif
            if (accept) begin
                req_q <= '{row: req_row, label: req_label, value: req_value};
                col_q <= '0;
            end
            // char/addr held from strobe until the next WR_ISSUE fire
            if (wr_fire) begin
                write_ascii_data <= char_c;
                write_base_addr  <= {req_q.row, col_q, 3'b000};
            end
            if ((state == WR_DONE) && write_ready && (col_q != 4'd15))
                col_q <= col_q + 4'd1;
        end
    end

endmodule
